traffic_light_monitor: RTL

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_light_monitor_pkg.sv | 28 ++
 rtl/light_tracker.sv | 60 ++++++
 rtl/traffic_light_monitor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/traffic_light_monitor_pkg.sv
// Shared lamp encoding, lamp indices and monitor state for the traffic light monitor.
package traffic_light_monitor_pkg;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam int NUM_LAMPS = 4;
    localparam int LAMP_M1   = 0;
    localparam int LAMP_S    = 1;
    localparam int LAMP_M2   = 2;
    localparam int LAMP_MT   = 3;

    typedef enum logic {
        SYNC  = 1'b0,
        CHECK = 1'b1
    } mon_state_t;

    function automatic logic is_onehot(input logic [2:0] lamp);
        return (lamp == RED) || (lamp == YEL) || (lamp == GRN);
    endfunction

    // A lamp lets traffic move (or finish moving) while green or yellow.
    function automatic logic is_active(input logic [2:0] lamp);
        return lamp[1] | lamp[0];
    endfunction

endpackage

// File: rtl/light_tracker.sv
// Per-lamp history: previous lamp state, transition legality and yellow dwell timing.
module light_tracker
    import traffic_light_monitor_pkg::*;
#(
    parameter int YEL_MIN = 2,
    parameter int YEL_MAX = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       chk_en,
    input  logic [2:0] sample,
    output logic       seq_err,
    output logic       tim_err
);

    localparam int            DW        = $clog2(YEL_MAX + 2);
    localparam logic [DW-1:0] DWELL_MIN = DW'(YEL_MIN);
    localparam logic [DW-1:0] DWELL_MAX = DW'(YEL_MAX);
    localparam logic [DW-1:0] DWELL_SAT = DW'(YEL_MAX + 1);

    logic [2:0]    prev;
    logic [DW-1:0] dwell;
    logic          sample_ok;
    logic          advance;

    assign sample_ok = is_onehot(sample);
    assign advance   = (load || chk_en) && sample_ok;

    // dwell holds the number of yellow samples seen so far in the current yellow interval.
    always_comb begin
        seq_err = 1'b0;
        tim_err = 1'b0;
        if (chk_en && sample_ok) begin
            seq_err = ((prev == GRN) && (sample == RED)) ||
                      ((prev == YEL) && (sample == GRN)) ||
                      ((prev == RED) && (sample == YEL));
            tim_err = (prev == YEL) &&
                      (((sample == RED) && (dwell < DWELL_MIN)) ||
                       ((sample == YEL) && (dwell == DWELL_MAX)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev  <= RED;
            dwell <= '0;
        end else if (advance) begin
            prev <= sample;
            if (sample != YEL) begin
                dwell <= '0;
            end else if (prev != YEL) begin
                dwell <= DW'(1);
            end else if (dwell != DWELL_SAT) begin
                dwell <= dwell + 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for a four-lamp intersection: encoding, conflict, sequence and yellow timing.
module traffic_light_monitor
    import traffic_light_monitor_pkg::*;
#(
    parameter int YEL_MIN = 2,
    parameter int YEL_MAX = 5,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light_M1,
    input  logic [2:0]       light_S,
    input  logic [2:0]       light_M2,
    input  logic [2:0]       light_MT,
    input  logic             clr_err,
    output logic             err_encoding,
    output logic             err_conflict,
    output logic             err_sequence,
    output logic             err_timing,
    output logic             err_any,
    output logic [CNT_W-1:0] violation_count,
    output logic             synced
);

    localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

    logic [NUM_LAMPS-1:0][2:0] lamp_p0;
    logic                      vld_p0;
    logic                      clr_p0;

    // Stage p0: register every lamp plus the clear so both line up with the checks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lamp_p0 <= {NUM_LAMPS{RED}};
            vld_p0  <= 1'b0;
            clr_p0  <= 1'b0;
        end else begin
            lamp_p0 <= {light_MT, light_M2, light_S, light_M1};
            vld_p0  <= 1'b1;
            clr_p0  <= clr_err;
        end
    end

    mon_state_t            state;
    logic [NUM_LAMPS-1:0]  lamp_ok;
    logic [NUM_LAMPS-1:0]  lamp_act;
    logic [NUM_LAMPS-1:0]  seq_err;
    logic [NUM_LAMPS-1:0]  tim_err;
    logic                  in_check;
    logic                  load;

    always_comb begin
        lamp_ok  = '0;
        lamp_act = '0;
        for (int i = 0; i < NUM_LAMPS; i++) begin
            lamp_ok[i]  = is_onehot(lamp_p0[i]);
            lamp_act[i] = is_active(lamp_p0[i]);
        end
    end

    assign in_check = (state == CHECK);
    assign load     = (state == SYNC) && vld_p0 && (&lamp_ok);

    for (genvar i = 0; i < NUM_LAMPS; i++) begin : g_trk
        light_tracker #(
            .YEL_MIN (YEL_MIN),
            .YEL_MAX (YEL_MAX)
        ) u_trk (
            .clk     (clk),
            .rst     (rst),
            .load    (load),
            .chk_en  (in_check),
            .sample  (lamp_p0[i]),
            .seq_err (seq_err[i]),
            .tim_err (tim_err[i])
        );
    end

    logic             enc_hit;
    logic             conf_hit;
    logic             seq_hit;
    logic             tim_hit;
    logic             violation;
    logic             nxt_enc;
    logic             nxt_conf;
    logic             nxt_seq;
    logic             nxt_tim;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] nxt_cnt;

    assign enc_hit  = in_check && !(&lamp_ok);
    assign conf_hit = in_check &&
                      ((lamp_act[LAMP_S] &&
                        (lamp_act[LAMP_M1] || lamp_act[LAMP_M2] || lamp_act[LAMP_MT])) ||
                       (lamp_act[LAMP_M2] && lamp_act[LAMP_MT]));
    assign seq_hit   = |seq_err;
    assign tim_hit   = |tim_err;
    assign violation = enc_hit || conf_hit || seq_hit || tim_hit;

    // A clear only wipes history; anything failing this cycle is re-recorded on top of it.
    always_comb begin
        nxt_enc  = (err_encoding && !clr_p0) || enc_hit;
        nxt_conf = (err_conflict && !clr_p0) || conf_hit;
        nxt_seq  = (err_sequence && !clr_p0) || seq_hit;
        nxt_tim  = (err_timing   && !clr_p0) || tim_hit;
        cnt_base = clr_p0 ? '0 : violation_count;
        nxt_cnt  = cnt_base;
        if (violation && (cnt_base != CNT_FULL)) begin
            nxt_cnt = cnt_base + 1'b1;
        end
    end

    // Stage p1: monitor state and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= SYNC;
            synced          <= 1'b0;
            err_encoding    <= 1'b0;
            err_conflict    <= 1'b0;
            err_sequence    <= 1'b0;
            err_timing      <= 1'b0;
            err_any         <= 1'b0;
            violation_count <= '0;
        end else begin
            case (state)
                SYNC: begin
                    if (load) begin
                        state  <= CHECK;
                        synced <= 1'b1;
                    end
                end
                CHECK: begin
                    err_encoding    <= nxt_enc;
                    err_conflict    <= nxt_conf;
                    err_sequence    <= nxt_seq;
                    err_timing      <= nxt_tim;
                    err_any         <= nxt_enc || nxt_conf || nxt_seq || nxt_tim;
                    violation_count <= nxt_cnt;
                end
                default: begin
                    state  <= SYNC;
                    synced <= 1'b0;
                end
            endcase
        end
    end

endmodule
